// File: rtl/snake_dir_queue_if.sv
// Key/step/start handshake and per-player direction outputs between the
// keyboard receiver, snake_dir_queue and the snake calculation block.
interface snake_dir_queue_if #(
    parameter int unsigned NUM_PLAYERS = 2
);
    logic                       start;
    logic                       step;
    logic [7:0]                 key;
    logic                       key_pressed;
    logic [2*NUM_PLAYERS-1:0]   snake_dir;
    logic [NUM_PLAYERS-1:0]     queue_full;
    logic [NUM_PLAYERS-1:0]     dropped;

    modport master (
        output start, step, key, key_pressed,
        input  snake_dir, queue_full, dropped
    );

    modport slave (
        input  start, step, key, key_pressed,
        output snake_dir, queue_full, dropped
    );
endinterface

// File: rtl/snake_dir_queue.sv
// Per-player scan-code decode with a pending-turn FIFO, popped one entry per game step.
// Optional macro SNAKE_DIR_QUEUE_REVERSE_FILTER_EN also rejects 180-degree reversals.
module snake_dir_queue #(
    parameter int unsigned                NUM_PLAYERS = 2,
    parameter int unsigned                QUEUE_DEPTH = 4,
    parameter logic [NUM_PLAYERS*32-1:0]  KEYMAP      = {8'h3B, 8'h42, 8'h4B, 8'h43,
                                                         8'h1C, 8'h1B, 8'h23, 8'h1D},
    parameter logic [NUM_PLAYERS*2-1:0]   INIT_DIR    = 4'b11_01
) (
    input logic              clk,
    input logic              rst,
    snake_dir_queue_if.slave bus
);

`ifdef SNAKE_DIR_QUEUE_REVERSE_FILTER_EN
    localparam bit RevFilter = 1'b1;
`else
    localparam bit RevFilter = 1'b0;
`endif

    localparam int unsigned PtrW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(QUEUE_DEPTH + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(QUEUE_DEPTH - 1);
    localparam logic [CntW-1:0] Depth   = CntW'(QUEUE_DEPTH);

    typedef logic [1:0] dir_t;

    dir_t              mem_q    [NUM_PLAYERS][QUEUE_DEPTH];
    dir_t              mem_d    [NUM_PLAYERS][QUEUE_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q [NUM_PLAYERS];
    logic [PtrW-1:0]   wr_ptr_d [NUM_PLAYERS];
    logic [PtrW-1:0]   rd_ptr_q [NUM_PLAYERS];
    logic [PtrW-1:0]   rd_ptr_d [NUM_PLAYERS];
    logic [CntW-1:0]   count_q  [NUM_PLAYERS];
    logic [CntW-1:0]   count_d  [NUM_PLAYERS];
    dir_t              dir_q    [NUM_PLAYERS];
    dir_t              dir_d    [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] dropped_q, dropped_d;

    always_comb begin
        logic            offer;
        logic            pass;
        logic            pop;
        logic            push;
        dir_t            cand;
        dir_t            ref_dir;
        logic [PtrW-1:0] tail;

        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        dir_d     = dir_q;
        dropped_d = '0;
        offer     = 1'b0;
        pass      = 1'b0;
        pop       = 1'b0;
        push      = 1'b0;
        cand      = '0;
        ref_dir   = '0;
        tail      = '0;

        for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
            offer = 1'b0;
            cand  = '0;
            // Lowest matching direction wins if a player's map has duplicate codes.
            if (bus.key_pressed) begin
                for (int d = 3; d >= 0; d--) begin
                    if (bus.key == KEYMAP[(p*4+d)*8 +: 8]) begin
                        offer = 1'b1;
                        cand  = dir_t'(d);
                    end
                end
            end

            tail    = (wr_ptr_q[p] == '0) ? LastPtr : wr_ptr_q[p] - PtrW'(1);
            ref_dir = (count_q[p] != '0) ? mem_q[p][tail] : dir_q[p];
            pass    = offer && (cand != ref_dir) &&
                      !(RevFilter && (cand == (ref_dir ^ 2'b10)));
            pop     = bus.step && (count_q[p] != '0);
            push    = pass && ((count_q[p] != Depth) || pop);
            dropped_d[p] = pass && !push;

            if (pop) begin
                dir_d[p]    = mem_q[p][rd_ptr_q[p]];
                rd_ptr_d[p] = (rd_ptr_q[p] == LastPtr) ? '0 : rd_ptr_q[p] + PtrW'(1);
            end
            if (push) begin
                mem_d[p][wr_ptr_q[p]] = cand;
                wr_ptr_d[p] = (wr_ptr_q[p] == LastPtr) ? '0 : wr_ptr_q[p] + PtrW'(1);
            end
            if (push && !pop) begin
                count_d[p] = count_q[p] + CntW'(1);
            end else if (pop && !push) begin
                count_d[p] = count_q[p] - CntW'(1);
            end

            // Restart overrides everything decided above, including this cycle's key.
            if (bus.start) begin
                wr_ptr_d[p] = '0;
                rd_ptr_d[p] = '0;
                count_d[p]  = '0;
                dir_d[p]    = INIT_DIR[2*p +: 2];
            end
        end

        if (bus.start) begin
            dropped_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
                for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
                    mem_q[p][i] <= '0;
                end
                wr_ptr_q[p] <= '0;
                rd_ptr_q[p] <= '0;
                count_q[p]  <= '0;
                dir_q[p]    <= INIT_DIR[2*p +: 2];
            end
            dropped_q <= '0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            dir_q     <= dir_d;
            dropped_q <= dropped_d;
        end
    end

    for (genvar p = 0; p < int'(NUM_PLAYERS); p++) begin : g_out
        assign bus.snake_dir[2*p +: 2] = dir_q[p];
        assign bus.queue_full[p]       = (count_q[p] == Depth);
    end

    assign bus.dropped = dropped_q;

endmodule
